// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB onto the TLB
// search port 1, write, read and invtlb ports and returns results to the
// CSR file over a done_valid/done_ready handshake.
// Ports: op_* request handshake, inv_* INVTLB operands, csr_* CSR
// snapshot, mem_* data-side translation (shares search port 1),
// tlb_* TLB port wiring, done_* result handshake and payload.
// ELO format (28b): {1'b0, ppn[19:0], g, mat[1:0], plv[1:0], d, v}.
// Build option: define TLB_FILL_LFSR_EN to pick fill slots from a
// 4-bit LFSR (TLBNUM must be 16) instead of a wrap-around counter.
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = $clog2(TLBNUM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_type,
  input  logic [4:0]       inv_op,
  input  logic [9:0]       inv_asid,
  input  logic [31:0]      inv_va,
  input  logic [9:0]       csr_asid,
  input  logic [18:0]      csr_ehi_vppn,
  input  logic [IDX_W-1:0] csr_idx,
  input  logic [5:0]       csr_ps,
  input  logic             csr_ne,
  input  logic [27:0]      csr_elo0,
  input  logic [27:0]      csr_elo1,
  input  logic             mem_req,
  input  logic [18:0]      mem_vppn,
  input  logic             mem_va_bit12,
  output logic             mem_grant,
  output logic [18:0]      tlb_s1_vppn,
  output logic             tlb_s1_va_bit12,
  output logic [9:0]       tlb_s1_asid,
  input  logic             tlb_s1_found,
  input  logic [IDX_W-1:0] tlb_s1_index,
  output logic             tlb_we,
  output logic [IDX_W-1:0] tlb_w_index,
  output logic             tlb_w_e,
  output logic [18:0]      tlb_w_vppn,
  output logic [5:0]       tlb_w_ps,
  output logic [9:0]       tlb_w_asid,
  output logic             tlb_w_g,
  output logic [19:0]      tlb_w_ppn0,
  output logic [1:0]       tlb_w_plv0,
  output logic [1:0]       tlb_w_mat0,
  output logic             tlb_w_d0,
  output logic             tlb_w_v0,
  output logic [19:0]      tlb_w_ppn1,
  output logic [1:0]       tlb_w_plv1,
  output logic [1:0]       tlb_w_mat1,
  output logic             tlb_w_d1,
  output logic             tlb_w_v1,
  output logic [IDX_W-1:0] tlb_r_index,
  input  logic             tlb_r_e,
  input  logic [18:0]      tlb_r_vppn,
  input  logic [5:0]       tlb_r_ps,
  input  logic [9:0]       tlb_r_asid,
  input  logic             tlb_r_g,
  input  logic [19:0]      tlb_r_ppn0,
  input  logic [1:0]       tlb_r_plv0,
  input  logic [1:0]       tlb_r_mat0,
  input  logic             tlb_r_d0,
  input  logic             tlb_r_v0,
  input  logic [19:0]      tlb_r_ppn1,
  input  logic [1:0]       tlb_r_plv1,
  input  logic [1:0]       tlb_r_mat1,
  input  logic             tlb_r_d1,
  input  logic             tlb_r_v1,
  output logic             tlb_invtlb_valid,
  output logic [4:0]       tlb_invtlb_op,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [2:0]       done_type,
  output logic             done_srch_hit,
  output logic [IDX_W-1:0] done_srch_idx,
  output logic             done_rd_e,
  output logic [18:0]      done_rd_vppn,
  output logic [5:0]       done_rd_ps,
  output logic [9:0]       done_rd_asid,
  output logic [27:0]      done_rd_elo0,
  output logic [27:0]      done_rd_elo1
);

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state, next_state;

  logic [2:0]       l_type;
  logic [4:0]       l_inv_op;
  logic [9:0]       l_inv_asid;
  logic [19:0]      l_inv_va;
  logic [9:0]       l_asid;
  logic [18:0]      l_vppn;
  logic [IDX_W-1:0] l_idx;
  logic [5:0]       l_ps;
  logic             l_ne;
  logic [26:0]      l_elo0;
  logic [26:0]      l_elo1;
  logic [IDX_W-1:0] l_fill;
  logic [IDX_W-1:0] fill_idx;

  logic is_srch, is_rd, is_wr, is_fill, is_inv;
  logic own_s1;
  logic rd_hit;
  logic accept;

  // Bits with no consumer: VA page offset and the ELO pad bit.
  logic unused_bits;
  assign unused_bits = ^{inv_va[11:0], csr_elo0[27], csr_elo1[27]};

`ifdef TLB_FILL_LFSR_EN
  // x^4+x^3+1, period 15; the all-zero state is unreachable.
  logic [3:0] lfsr;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= 4'b0001;
    else       lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
  end
  assign fill_idx = IDX_W'(lfsr);
`else
  logic [IDX_W-1:0] fill_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fill_cnt <= '0;
    else       fill_cnt <= fill_cnt + IDX_W'(1);
  end
  assign fill_idx = fill_cnt;
`endif

  assign is_srch = (l_type == OP_SRCH);
  assign is_rd   = (l_type == OP_RD);
  assign is_wr   = (l_type == OP_WR);
  assign is_fill = (l_type == OP_FILL);
  assign is_inv  = (l_type == OP_INV);
  assign accept  = op_valid & op_ready;
  assign rd_hit  = is_rd & tlb_r_e;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state       = state;
    op_ready         = 1'b0;
    done_valid       = 1'b0;
    tlb_we           = 1'b0;
    tlb_invtlb_valid = 1'b0;
    own_s1           = 1'b0;
    unique case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) next_state = EXEC;
      end
      EXEC: begin
        tlb_we           = is_wr | is_fill;
        tlb_invtlb_valid = is_inv;
        own_s1           = is_srch | is_inv;
        next_state       = RESP;
      end
      RESP: begin
        done_valid = 1'b1;
        if (done_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Search port 1: the controller wins; the data side retries.
  always_comb begin
    tlb_s1_vppn     = mem_vppn;
    tlb_s1_va_bit12 = mem_va_bit12;
    tlb_s1_asid     = csr_asid;
    if (own_s1 && is_inv) begin
      tlb_s1_vppn     = l_inv_va[19:1];
      tlb_s1_va_bit12 = l_inv_va[0];
      tlb_s1_asid     = l_inv_asid;
    end else if (own_s1) begin
      tlb_s1_vppn     = l_vppn;
      tlb_s1_va_bit12 = 1'b0;
      tlb_s1_asid     = l_asid;
    end
  end
  assign mem_grant = mem_req & ~own_s1;

  assign tlb_w_index = is_fill ? l_fill : l_idx;
  assign tlb_w_e     = ~l_ne;
  assign tlb_w_vppn  = l_vppn;
  assign tlb_w_ps    = l_ps;
  assign tlb_w_asid  = l_asid;
  assign tlb_w_g     = l_elo0[6] & l_elo1[6];
  assign tlb_w_ppn0  = l_elo0[26:7];
  assign tlb_w_mat0  = l_elo0[5:4];
  assign tlb_w_plv0  = l_elo0[3:2];
  assign tlb_w_d0    = l_elo0[1];
  assign tlb_w_v0    = l_elo0[0];
  assign tlb_w_ppn1  = l_elo1[26:7];
  assign tlb_w_mat1  = l_elo1[5:4];
  assign tlb_w_plv1  = l_elo1[3:2];
  assign tlb_w_d1    = l_elo1[1];
  assign tlb_w_v1    = l_elo1[0];

  assign tlb_r_index   = l_idx;
  assign tlb_invtlb_op = l_inv_op;
  assign done_type     = l_type;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_type        <= '0;
      l_inv_op      <= '0;
      l_inv_asid    <= '0;
      l_inv_va      <= '0;
      l_asid        <= '0;
      l_vppn        <= '0;
      l_idx         <= '0;
      l_ps          <= '0;
      l_ne          <= 1'b0;
      l_elo0        <= '0;
      l_elo1        <= '0;
      l_fill        <= '0;
      done_srch_hit <= 1'b0;
      done_srch_idx <= '0;
      done_rd_e     <= 1'b0;
      done_rd_vppn  <= '0;
      done_rd_ps    <= '0;
      done_rd_asid  <= '0;
      done_rd_elo0  <= '0;
      done_rd_elo1  <= '0;
    end else begin
      if (accept) begin
        l_type     <= op_type;
        l_inv_op   <= inv_op;
        l_inv_asid <= inv_asid;
        l_inv_va   <= inv_va[31:12];
        l_asid     <= csr_asid;
        l_vppn     <= csr_ehi_vppn;
        l_idx      <= csr_idx;
        l_ps       <= csr_ps;
        l_ne       <= csr_ne;
        l_elo0     <= csr_elo0[26:0];
        l_elo1     <= csr_elo1[26:0];
        l_fill     <= fill_idx;
      end
      if (state == EXEC) begin
        done_srch_hit <= is_srch & tlb_s1_found;
        done_srch_idx <= is_srch ? tlb_s1_index : '0;
        // An invalid entry reads back as all zeros.
        done_rd_e     <= rd_hit;
        done_rd_vppn  <= rd_hit ? tlb_r_vppn : '0;
        done_rd_ps    <= rd_hit ? tlb_r_ps : '0;
        done_rd_asid  <= rd_hit ? tlb_r_asid : '0;
        done_rd_elo0  <= rd_hit ?
          {1'b0, tlb_r_ppn0, tlb_r_g, tlb_r_mat0,
           tlb_r_plv0, tlb_r_d0, tlb_r_v0} : '0;
        done_rd_elo1  <= rd_hit ?
          {1'b0, tlb_r_ppn1, tlb_r_g, tlb_r_mat1,
           tlb_r_plv1, tlb_r_d1, tlb_r_v1} : '0;
      end
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Testbench for tlb_op_ctrl: small behavioural TLB model plus an
// expected-result queue drained on each done handshake.
module tb_tlb_op_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_ready;
  logic [2:0]  op_type;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [31:0] inv_va;
  logic [9:0]  csr_asid;
  logic [18:0] csr_ehi_vppn;
  logic [3:0]  csr_idx;
  logic [5:0]  csr_ps;
  logic        csr_ne;
  logic [27:0] csr_elo0, csr_elo1;
  logic        mem_req, mem_va_bit12, mem_grant;
  logic [18:0] mem_vppn;
  logic [18:0] tlb_s1_vppn;
  logic        tlb_s1_va_bit12;
  logic [9:0]  tlb_s1_asid;
  logic        tlb_s1_found;
  logic [3:0]  tlb_s1_index;
  logic        tlb_we;
  logic [3:0]  tlb_w_index;
  logic        tlb_w_e, tlb_w_g;
  logic [18:0] tlb_w_vppn;
  logic [5:0]  tlb_w_ps;
  logic [9:0]  tlb_w_asid;
  logic [19:0] tlb_w_ppn0, tlb_w_ppn1;
  logic [1:0]  tlb_w_plv0, tlb_w_mat0, tlb_w_plv1, tlb_w_mat1;
  logic        tlb_w_d0, tlb_w_v0, tlb_w_d1, tlb_w_v1;
  logic [3:0]  tlb_r_index;
  logic        tlb_r_e, tlb_r_g;
  logic [18:0] tlb_r_vppn;
  logic [5:0]  tlb_r_ps;
  logic [9:0]  tlb_r_asid;
  logic [19:0] tlb_r_ppn0, tlb_r_ppn1;
  logic [1:0]  tlb_r_plv0, tlb_r_mat0, tlb_r_plv1, tlb_r_mat1;
  logic        tlb_r_d0, tlb_r_v0, tlb_r_d1, tlb_r_v1;
  logic        tlb_invtlb_valid;
  logic [4:0]  tlb_invtlb_op;
  logic        done_valid, done_ready;
  logic [2:0]  done_type;
  logic        done_srch_hit;
  logic [3:0]  done_srch_idx;
  logic        done_rd_e;
  logic [18:0] done_rd_vppn;
  logic [5:0]  done_rd_ps;
  logic [9:0]  done_rd_asid;
  logic [27:0] done_rd_elo0, done_rd_elo1;

  tlb_op_ctrl #(.TLBNUM(16)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
    .csr_asid(csr_asid), .csr_ehi_vppn(csr_ehi_vppn),
    .csr_idx(csr_idx), .csr_ps(csr_ps), .csr_ne(csr_ne),
    .csr_elo0(csr_elo0), .csr_elo1(csr_elo1),
    .mem_req(mem_req), .mem_vppn(mem_vppn),
    .mem_va_bit12(mem_va_bit12), .mem_grant(mem_grant),
    .tlb_s1_vppn(tlb_s1_vppn), .tlb_s1_va_bit12(tlb_s1_va_bit12),
    .tlb_s1_asid(tlb_s1_asid), .tlb_s1_found(tlb_s1_found),
    .tlb_s1_index(tlb_s1_index),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e),
    .tlb_w_vppn(tlb_w_vppn), .tlb_w_ps(tlb_w_ps),
    .tlb_w_asid(tlb_w_asid), .tlb_w_g(tlb_w_g),
    .tlb_w_ppn0(tlb_w_ppn0), .tlb_w_plv0(tlb_w_plv0),
    .tlb_w_mat0(tlb_w_mat0), .tlb_w_d0(tlb_w_d0), .tlb_w_v0(tlb_w_v0),
    .tlb_w_ppn1(tlb_w_ppn1), .tlb_w_plv1(tlb_w_plv1),
    .tlb_w_mat1(tlb_w_mat1), .tlb_w_d1(tlb_w_d1), .tlb_w_v1(tlb_w_v1),
    .tlb_r_index(tlb_r_index), .tlb_r_e(tlb_r_e),
    .tlb_r_vppn(tlb_r_vppn), .tlb_r_ps(tlb_r_ps),
    .tlb_r_asid(tlb_r_asid), .tlb_r_g(tlb_r_g),
    .tlb_r_ppn0(tlb_r_ppn0), .tlb_r_plv0(tlb_r_plv0),
    .tlb_r_mat0(tlb_r_mat0), .tlb_r_d0(tlb_r_d0), .tlb_r_v0(tlb_r_v0),
    .tlb_r_ppn1(tlb_r_ppn1), .tlb_r_plv1(tlb_r_plv1),
    .tlb_r_mat1(tlb_r_mat1), .tlb_r_d1(tlb_r_d1), .tlb_r_v1(tlb_r_v1),
    .tlb_invtlb_valid(tlb_invtlb_valid), .tlb_invtlb_op(tlb_invtlb_op),
    .done_valid(done_valid), .done_ready(done_ready),
    .done_type(done_type), .done_srch_hit(done_srch_hit),
    .done_srch_idx(done_srch_idx), .done_rd_e(done_rd_e),
    .done_rd_vppn(done_rd_vppn), .done_rd_ps(done_rd_ps),
    .done_rd_asid(done_rd_asid), .done_rd_elo0(done_rd_elo0),
    .done_rd_elo1(done_rd_elo1)
  );

  always #5 clk = ~clk;

  // Behavioural TLB
  logic        m_e[16];
  logic [18:0] m_vppn[16];
  logic [5:0]  m_ps[16];
  logic [9:0]  m_asid[16];
  logic        m_g[16];
  logic [25:0] m_p0[16];
  logic [25:0] m_p1[16];

  initial for (int i = 0; i < 16; i++) m_e[i] = 1'b0;

  always @(posedge clk) begin
    if (tlb_we) begin
      m_e[tlb_w_index]    <= tlb_w_e;
      m_vppn[tlb_w_index] <= tlb_w_vppn;
      m_ps[tlb_w_index]   <= tlb_w_ps;
      m_asid[tlb_w_index] <= tlb_w_asid;
      m_g[tlb_w_index]    <= tlb_w_g;
      m_p0[tlb_w_index]   <= {tlb_w_ppn0, tlb_w_mat0, tlb_w_plv0,
                              tlb_w_d0, tlb_w_v0};
      m_p1[tlb_w_index]   <= {tlb_w_ppn1, tlb_w_mat1, tlb_w_plv1,
                              tlb_w_d1, tlb_w_v1};
    end
    if (tlb_invtlb_valid) begin
      for (int i = 0; i < 16; i++) begin
        case (tlb_invtlb_op)
          5'd0, 5'd1: m_e[i] <= 1'b0;
          5'd2: if (m_g[i]) m_e[i] <= 1'b0;
          5'd3: if (!m_g[i]) m_e[i] <= 1'b0;
          5'd4: if (!m_g[i] && m_asid[i] == tlb_s1_asid) m_e[i] <= 1'b0;
          5'd5: if (!m_g[i] && m_asid[i] == tlb_s1_asid &&
                    m_vppn[i] == tlb_s1_vppn) m_e[i] <= 1'b0;
          5'd6: if ((m_g[i] || m_asid[i] == tlb_s1_asid) &&
                    m_vppn[i] == tlb_s1_vppn) m_e[i] <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    tlb_s1_found = 1'b0;
    tlb_s1_index = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m_e[i] && m_vppn[i] == tlb_s1_vppn &&
          (m_g[i] || m_asid[i] == tlb_s1_asid)) begin
        tlb_s1_found = 1'b1;
        tlb_s1_index = 4'(i);
      end
    end
  end

  assign tlb_r_e    = m_e[tlb_r_index];
  assign tlb_r_vppn = m_vppn[tlb_r_index];
  assign tlb_r_ps   = m_ps[tlb_r_index];
  assign tlb_r_asid = m_asid[tlb_r_index];
  assign tlb_r_g    = m_g[tlb_r_index];
  assign {tlb_r_ppn0, tlb_r_mat0, tlb_r_plv0, tlb_r_d0, tlb_r_v0} =
    m_p0[tlb_r_index];
  assign {tlb_r_ppn1, tlb_r_mat1, tlb_r_plv1, tlb_r_d1, tlb_r_v1} =
    m_p1[tlb_r_index];

  // Scoreboard
  typedef struct {
    logic [2:0]  t;
    logic        hit;
    logic [3:0]  idx;
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic [27:0] lo0;
    logic [27:0] lo1;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;
  int   fails  = 0;

  function automatic exp_t mk(
    input logic [2:0] t, input logic hit, input logic [3:0] idx,
    input logic e, input logic [18:0] vppn, input logic [5:0] ps,
    input logic [9:0] asid, input logic [27:0] lo0,
    input logic [27:0] lo1);
    exp_t r;
    r.t = t; r.hit = hit; r.idx = idx; r.e = e; r.vppn = vppn;
    r.ps = ps; r.asid = asid; r.lo0 = lo0; r.lo1 = lo1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp(input exp_t x);
    chk("done_type", done_type, x.t);
    chk("srch_hit", done_srch_hit, x.hit);
    chk("srch_idx", done_srch_idx, x.idx);
    chk("rd_e", done_rd_e, x.e);
    chk("rd_vppn", done_rd_vppn, x.vppn);
    chk("rd_ps", done_rd_ps, x.ps);
    chk("rd_asid", done_rd_asid, x.asid);
    chk("rd_elo0", done_rd_elo0, x.lo0);
    chk("rd_elo1", done_rd_elo1, x.lo1);
  endtask

  // One complete operation, entered and left at a negedge.
  task automatic go(input exp_t x, input logic [3:0] widx,
                    input logic [18:0] s1v, input int hold);
    int   n;
    exp_t y;
    chk("op_ready_idle", op_ready, 1);
    chk("grant_idle", mem_grant, 1);
    op_type  = x.t;
    op_valid = 1'b1;
    if (hold > 0) done_ready = 1'b0;
    q.push_back(x);
    @(negedge clk);
    op_valid = 1'b0;
    case (x.t)
      3'd2, 3'd3: begin
        chk("we_exec", tlb_we, 1);
        chk("w_index", tlb_w_index, widx);
        chk("w_e", tlb_w_e, !csr_ne);
        chk("w_g", tlb_w_g, csr_elo0[6] & csr_elo1[6]);
        chk("w_vppn", tlb_w_vppn, csr_ehi_vppn);
        chk("grant_wr", mem_grant, 1);
      end
      3'd4: begin
        chk("inv_valid", tlb_invtlb_valid, 1);
        chk("inv_op", tlb_invtlb_op, inv_op);
        chk("inv_s1_vppn", tlb_s1_vppn, s1v);
        chk("inv_s1_b12", tlb_s1_va_bit12, inv_va[12]);
        chk("inv_s1_asid", tlb_s1_asid, inv_asid);
        chk("grant_inv", mem_grant, 0);
      end
      3'd0: begin
        chk("srch_s1_vppn", tlb_s1_vppn, s1v);
        chk("srch_s1_b12", tlb_s1_va_bit12, 0);
        chk("grant_srch", mem_grant, 0);
        chk("we_srch", tlb_we, 0);
      end
      default: begin
        chk("r_index", tlb_r_index, csr_idx);
        chk("grant_rd", mem_grant, 1);
      end
    endcase
    @(negedge clk);
    chk("we_resp", tlb_we, 0);
    chk("inv_resp", tlb_invtlb_valid, 0);
    chk("grant_resp", mem_grant, 1);
    n = 0;
    while (!done_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("done_valid", done_valid, 1);
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", done_valid, 1);
      chk("hold_ready", op_ready, 0);
      if (q.size() > 0) cmp(q[0]);
      @(negedge clk);
    end
    done_ready = 1'b1;
    if (q.size() > 0) begin
      y = q.pop_front();
      cmp(y);
    end
    @(negedge clk);
    chk("done_clear", done_valid, 0);
  endtask

  logic [3:0] fill_exp;

  initial begin
    reset = 1'b1;
    op_valid = 1'b0; op_type = 3'd0;
    inv_op = 5'd0; inv_asid = 10'd0; inv_va = 32'd0;
    csr_asid = 10'h11; csr_ehi_vppn = 19'd0; csr_idx = 4'd0;
    csr_ps = 6'd12; csr_ne = 1'b0;
    csr_elo0 = 28'd0; csr_elo1 = 28'd0;
    mem_req = 1'b1; mem_vppn = 19'h70001; mem_va_bit12 = 1'b1;
    done_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_we", tlb_we, 0);
    chk("rst_inv", tlb_invtlb_valid, 0);
    chk("rst_s1_vppn", tlb_s1_vppn, 19'h70001);
    chk("rst_payload", done_rd_elo0, 0);
    reset = 1'b0;
    @(negedge clk);

    // Preload entry 5, then search it
    csr_idx = 4'd5; csr_ehi_vppn = 19'h12345;
    csr_elo0 = {1'b0, 20'h00100, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1};
    csr_elo1 = {1'b0, 20'h00101, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1};
    go(mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0), 4'd5, 0, 0);
    csr_idx = 4'd0;
    go(mk(3'd0, 1, 4'd5, 0, 0, 0, 0, 0, 0), 0, 19'h12345, 0);

    // WR idx 3 with mixed G, then RD with done_ready held low
    csr_idx = 4'd3; csr_ehi_vppn = 19'h0ABCD; csr_ps = 6'd12;
    csr_elo0 = {1'b0, 20'h12345, 1'b1, 2'b01, 2'b00, 1'b1, 1'b1};
    csr_elo1 = {1'b0, 20'h54321, 1'b0, 2'b10, 2'b11, 1'b0, 1'b1};
    go(mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0), 4'd3, 0, 0);
    csr_ehi_vppn = 19'd0;
    go(mk(3'd1, 0, 0, 1, 19'h0ABCD, 6'd12, 10'h11,
          {1'b0, 20'h12345, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1},
          {1'b0, 20'h54321, 1'b0, 2'b10, 2'b11, 1'b0, 1'b1}),
       0, 0, 4);

    // WR with NE=1 reads back all zero
    csr_idx = 4'd4; csr_ne = 1'b1; csr_ehi_vppn = 19'h03333;
    go(mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0), 4'd4, 0, 0);
    csr_ne = 1'b0;
    go(mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0);

    // INVTLB op 5 removes a matching non-global entry
    csr_asid = 10'h2A; csr_idx = 4'd6; csr_ehi_vppn = 19'h00201;
    csr_elo0 = {1'b0, 20'h00200, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
    csr_elo1 = {1'b0, 20'h00201, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
    go(mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0), 4'd6, 0, 0);
    inv_op = 5'd5; inv_asid = 10'h2A; inv_va = 32'h00403000;
    go(mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 0), 0, 19'h00201, 0);
    go(mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 19'h00201, 0);

    // INVTLB op 9: strobe and done, nothing removed
    inv_op = 5'd9;
    go(mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 0), 0, 19'h00201, 0);
    csr_asid = 10'h11; csr_ehi_vppn = 19'h12345;
    go(mk(3'd0, 1, 4'd5, 0, 0, 0, 0, 0, 0), 0, 19'h12345, 0);

    // FILL issued with 7 cycles elapsed since reset release
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (7) @(negedge clk);
`ifdef TLB_FILL_LFSR_EN
    fill_exp = 4'hA;
`else
    fill_exp = 4'h7;
`endif
    csr_idx = 4'd2; csr_ehi_vppn = 19'h0F0F0; csr_ps = 6'd21;
    csr_elo0 = {1'b0, 20'hAAAAA, 1'b1, 2'b11, 2'b10, 1'b0, 1'b1};
    csr_elo1 = {1'b0, 20'h55555, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0};
    go(mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0), fill_exp, 0, 0);
    csr_idx = fill_exp;
    go(mk(3'd1, 0, 0, 1, 19'h0F0F0, 6'd21, 10'h11,
          {1'b0, 20'hAAAAA, 1'b1, 2'b11, 2'b10, 1'b0, 1'b1},
          {1'b0, 20'h55555, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0}),
       0, 0, 0);

    // Reset in EXEC of WR abandons the op
    csr_idx = 4'd9; csr_ehi_vppn = 19'h0AAAA; csr_ps = 6'd12;
    op_type = 3'd2; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    chk("abort_we_exec", tlb_we, 1);
    reset = 1'b1;
    #1;
    chk("abort_we_rst", tlb_we, 0);
    chk("abort_done_rst", done_valid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_we", tlb_we, 0);
      chk("abort_done", done_valid, 0);
      chk("abort_inv", tlb_invtlb_valid, 0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("abort_no_done", done_valid, 0);
    go(mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
